// File: rtl/serdesphy_ana_cdr_pi.sv
// Second-order bang-bang CDR: Alexander phase detector, PI loop filter driving
// the VCO control word, and a windowed lock detector with hysteresis and HOLD.
module serdesphy_ana_cdr_pi #(
  parameter int unsigned CTRL_W         = 8,
  parameter int unsigned INT_W          = 14,
  parameter int unsigned LOCK_WIN_LOG2  = 6,
  parameter int unsigned LOCK_THRESH    = 4,
  parameter int unsigned LOCK_WINDOWS   = 8,
  parameter int unsigned UNLOCK_WINDOWS = 2
) (
  input  logic              clk_240m_rx,
  input  logic              rst,
  input  logic              cdr_rst,
  input  logic              enable,
  input  logic [2:0]        cdr_gain,
  input  logic              cdr_fast_lock,
  input  logic              data_sample,
  input  logic              edge_sample,
  output logic [CTRL_W-1:0] vco_control,
  output logic              pd_up,
  output logic              pd_dn,
  output logic [INT_W-1:0]  integ_out,
  output logic [1:0]        cdr_state,
  output logic              cdr_lock
);

  localparam int unsigned CNT_W  = LOCK_WIN_LOG2 + 1;
  localparam int unsigned GOOD_W = $clog2(LOCK_WINDOWS + 1);
  localparam int unsigned UNL_W  = $clog2(UNLOCK_WINDOWS + 1);
  localparam int unsigned SUM_W  = CTRL_W + 3;
  localparam int unsigned SH     = INT_W - CTRL_W;
  localparam logic [SUM_W-1:0] MID = SUM_W'(2 ** (CTRL_W - 1));

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACQ    = 2'd1,
    ST_LOCKED = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  state_e                    state_q, state_d;
  logic                      lock_q, lock_d;
  logic                      d_prev_q;
  logic                      pd_up_q, pd_up_d, pd_dn_q, pd_dn_d;
  logic [INT_W-1:0]          integ_q, integ_d;
  logic [CTRL_W-1:0]         vco_q, vco_d;
  logic [LOCK_WIN_LOG2-1:0]  win_q, win_d;
  logic [CNT_W-1:0]          ups_q, ups_d, dns_q, dns_d, trans_q, trans_d;
  logic [GOOD_W-1:0]         good_q, good_d;
  logic [UNL_W-1:0]          bad_q, bad_d, empty_q, empty_d;

  logic             trans_c, win_end_c, empty_c, good_c, bad_c, fast_c;
  logic [CNT_W-1:0] ups_tot_c, dns_tot_c, trans_tot_c, diff_c;
  logic [3:0]       kp_sum_c;
  logic [2:0]       kp_c;
  logic [INT_W:0]   integ_ext_c, step_c, integ_sum_c;
  logic [SUM_W-1:0] integ_term_c, prop_mag_c, prop_c, vco_sum_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    sat_inc = (inc && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Phase detector decisions and per-window statistics
  always_comb begin
    trans_c     = d_prev_q ^ data_sample;
    pd_up_d     = trans_c & (edge_sample == data_sample);
    pd_dn_d     = trans_c & (edge_sample == d_prev_q);
    ups_tot_c   = sat_inc(ups_q, pd_up_d);
    dns_tot_c   = sat_inc(dns_q, pd_dn_d);
    trans_tot_c = sat_inc(trans_q, trans_c);
    diff_c      = (ups_tot_c >= dns_tot_c) ? ups_tot_c - dns_tot_c : dns_tot_c - ups_tot_c;
    win_end_c   = (win_q == '1);
    empty_c     = (trans_tot_c == '0);
    good_c      = !empty_c && (32'(diff_c) <= LOCK_THRESH);
    bad_c       = !empty_c && !good_c;
    win_d       = win_q + LOCK_WIN_LOG2'(1);
    ups_d       = win_end_c ? '0 : ups_tot_c;
    dns_d       = win_end_c ? '0 : dns_tot_c;
    trans_d     = win_end_c ? '0 : trans_tot_c;
  end

  // Lock FSM: window verdicts move between acquire, locked and hold
  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    bad_d   = bad_q;
    empty_d = empty_q;
    case (state_q)
      ST_IDLE: state_d = ST_ACQ;
      ST_ACQ: if (win_end_c) begin
        if (good_c) begin
          if (32'(good_q) + 32'd1 >= LOCK_WINDOWS) begin
            state_d = ST_LOCKED;
            good_d  = '0;
            bad_d   = '0;
          end else begin
            good_d = good_q + GOOD_W'(1);
          end
        end else begin
          good_d = '0;
        end
      end
      ST_LOCKED: if (win_end_c) begin
        if (empty_c) begin
          state_d = ST_HOLD;
          bad_d   = '0;
          empty_d = '0;
        end else if (good_c) begin
          bad_d = '0;
        end else if (32'(bad_q) + 32'd1 >= UNLOCK_WINDOWS) begin
          state_d = ST_ACQ;
          bad_d   = '0;
          good_d  = '0;
        end else begin
          bad_d = bad_q + UNL_W'(1);
        end
      end
      ST_HOLD: if (win_end_c) begin
        if (good_c) begin
          state_d = ST_LOCKED;
          empty_d = '0;
          bad_d   = '0;
        end else if (bad_c) begin
          state_d = ST_ACQ;
          empty_d = '0;
          good_d  = '0;
        end else if (32'(empty_q) + 32'd1 >= UNLOCK_WINDOWS) begin
          state_d = ST_ACQ;
          empty_d = '0;
          good_d  = '0;
        end else begin
          empty_d = empty_q + UNL_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
    lock_d = (state_d == ST_LOCKED) || (state_d == ST_HOLD);
  end

  // PI loop filter on the registered phase decision
  always_comb begin
    fast_c       = (state_q == ST_ACQ) && cdr_fast_lock;
    kp_sum_c     = {1'b0, cdr_gain} + {3'b000, fast_c};
    kp_c         = (kp_sum_c > 4'd7) ? 3'd7 : kp_sum_c[2:0];
    step_c       = fast_c ? (INT_W+1)'(4) : (INT_W+1)'(1);
    integ_ext_c  = {integ_q[INT_W-1], integ_q};
    integ_sum_c  = integ_ext_c;
    if (pd_up_q)      integ_sum_c = integ_ext_c + step_c;
    else if (pd_dn_q) integ_sum_c = integ_ext_c - step_c;
    integ_d = integ_sum_c[INT_W-1:0];
    if (integ_sum_c[INT_W] != integ_sum_c[INT_W-1])
      integ_d = integ_sum_c[INT_W] ? {1'b1, {(INT_W-1){1'b0}}} : {1'b0, {(INT_W-1){1'b1}}};
    prop_mag_c = SUM_W'(1) << kp_c;
    prop_c     = '0;
    if (pd_up_q)      prop_c = prop_mag_c;
    else if (pd_dn_q) prop_c = -prop_mag_c;
    if (state_q == ST_HOLD) begin
      integ_d = integ_q;
      prop_c  = '0;
    end
    integ_term_c = {{3{integ_q[INT_W-1]}}, integ_q[INT_W-1:SH]};
    vco_sum_c    = MID + integ_term_c + prop_c;
    if (vco_sum_c[SUM_W-1])               vco_d = '0;
    else if (vco_sum_c[SUM_W-2:CTRL_W] != '0) vco_d = '1;
    else                                  vco_d = vco_sum_c[CTRL_W-1:0];
  end

  // State registers; reset and disable both return the loop to mid-scale IDLE
  always_ff @(posedge clk_240m_rx) begin
    if (rst || cdr_rst || !enable) begin
      state_q <= ST_IDLE;
      lock_q  <= 1'b0;
      pd_up_q <= 1'b0;
      pd_dn_q <= 1'b0;
      integ_q <= '0;
      vco_q   <= CTRL_W'(MID);
      win_q   <= '0;
      ups_q   <= '0;
      dns_q   <= '0;
      trans_q <= '0;
      good_q  <= '0;
      bad_q   <= '0;
      empty_q <= '0;
      if (rst || cdr_rst) d_prev_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      lock_q   <= lock_d;
      pd_up_q  <= pd_up_d;
      pd_dn_q  <= pd_dn_d;
      integ_q  <= integ_d;
      vco_q    <= vco_d;
      win_q    <= win_d;
      ups_q    <= ups_d;
      dns_q    <= dns_d;
      trans_q  <= trans_d;
      good_q   <= good_d;
      bad_q    <= bad_d;
      empty_q  <= empty_d;
      d_prev_q <= data_sample;
    end
  end

  assign vco_control = vco_q;
  assign pd_up       = pd_up_q;
  assign pd_dn       = pd_dn_q;
  assign integ_out   = integ_q;
  assign cdr_state   = state_q;
  assign cdr_lock    = lock_q;

endmodule

// File: tb/tb_serdesphy_ana_cdr_pi.sv
// Bench for serdesphy_ana_cdr_pi: arithmetic reference model compared every
// cycle, plus literal expectations from hand-worked scenarios.
module tb_serdesphy_ana_cdr_pi;

  logic       clk_240m_rx = 1'b0;
  logic       rst, cdr_rst, enable, cdr_fast_lock, data_sample, edge_sample;
  logic [2:0] cdr_gain;
  logic [7:0] vco_control;
  logic       pd_up, pd_dn, cdr_lock;
  logic [13:0] integ_out;
  logic [1:0] cdr_state;

  always #5 clk_240m_rx = ~clk_240m_rx;

  serdesphy_ana_cdr_pi dut (
    .clk_240m_rx  (clk_240m_rx),
    .rst          (rst),
    .cdr_rst      (cdr_rst),
    .enable       (enable),
    .cdr_gain     (cdr_gain),
    .cdr_fast_lock(cdr_fast_lock),
    .data_sample  (data_sample),
    .edge_sample  (edge_sample),
    .vco_control  (vco_control),
    .pd_up        (pd_up),
    .pd_dn        (pd_dn),
    .integ_out    (integ_out),
    .cdr_state    (cdr_state),
    .cdr_lock     (cdr_lock)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;
  bit dcur = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state (plain integers)
  int m_dprev, m_pd, m_integ, m_vco, m_state, m_lock, m_pu, m_pdn;
  int m_w, m_up, m_dn, m_tr, m_good, m_bad, m_empty;

  function automatic int floor64(input int x);
    floor64 = (x >= 0) ? x / 64 : -((-x + 63) / 64);
  endfunction

  function automatic int clampi(input int x, input int lo, input int hi);
    clampi = (x < lo) ? lo : (x > hi) ? hi : x;
  endfunction

  task automatic model_clear();
    m_pd = 0; m_integ = 0; m_vco = 128; m_state = 0; m_lock = 0;
    m_pu = 0; m_pdn = 0; m_w = 0; m_up = 0; m_dn = 0; m_tr = 0;
    m_good = 0; m_bad = 0; m_empty = 0;
  endtask

  always @(posedge clk_240m_rx) begin
    int kp, kim, nint, prop, npd, nst, v, diff;
    bit fastacq;
    if (rst || cdr_rst) begin
      model_clear();
      m_dprev = 0;
    end else if (!enable) begin
      model_clear();
    end else begin
      fastacq = (m_state == 1) && cdr_fast_lock;
      kp  = int'(cdr_gain) + (fastacq ? 1 : 0);
      if (kp > 7) kp = 7;
      kim = fastacq ? 4 : 1;
      if (m_state == 3) begin
        nint = m_integ;
        prop = 0;
      end else begin
        nint = clampi(m_integ + m_pd * kim, -8192, 8191);
        prop = m_pd * (1 << kp);
      end
      m_vco   = clampi(128 + floor64(m_integ) + prop, 0, 255);
      m_integ = nint;
      npd = (data_sample == m_dprev[0]) ? 0 : (edge_sample == data_sample) ? 1 : -1;
      m_pd = npd; m_pu = (npd == 1); m_pdn = (npd == -1);
      m_up += (npd == 1); m_dn += (npd == -1); m_tr += (npd != 0);
      nst = m_state;
      if (m_state == 0) nst = 1;
      else if (m_w == 63) begin
        diff = (m_up > m_dn) ? m_up - m_dn : m_dn - m_up;
        v = (m_tr == 0) ? 0 : (diff <= 4) ? 1 : 2;
        case (m_state)
          1: if (v == 1) begin
               m_good++;
               if (m_good >= 8) begin nst = 2; m_good = 0; m_bad = 0; end
             end else m_good = 0;
          2: if (v == 0) begin nst = 3; m_bad = 0; m_empty = 0; end
             else if (v == 1) m_bad = 0;
             else begin
               m_bad++;
               if (m_bad >= 2) begin nst = 1; m_bad = 0; m_good = 0; end
             end
          default: if (v == 1) begin nst = 2; m_empty = 0; m_bad = 0; end
             else if (v == 2) begin nst = 1; m_empty = 0; m_good = 0; end
             else begin
               m_empty++;
               if (m_empty >= 2) begin nst = 1; m_empty = 0; m_good = 0; end
             end
        endcase
      end
      if (m_w == 63) begin m_up = 0; m_dn = 0; m_tr = 0; end
      m_w = (m_w + 1) % 64;
      m_state = nst;
      m_lock  = (nst >= 2);
      m_dprev = data_sample;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk_240m_rx) begin
    if (chk_on) begin
      chk("vco_control", vco_control, m_vco);
      chk("integ_out", $signed(integ_out), m_integ);
      chk("pd_up", pd_up, m_pu);
      chk("pd_dn", pd_dn, m_pdn);
      chk("cdr_state", cdr_state, m_state);
      chk("cdr_lock", cdr_lock, m_lock);
    end
  end

  task automatic tick(input logic d, input logic e);
    data_sample = d;
    edge_sample = e;
    @(posedge clk_240m_rx);
    #2;
  endtask

  // One data transition; up=1 advances, up=0 retards
  task automatic alt(input bit up);
    dcur = ~dcur;
    tick(dcur, up ? dcur : ~dcur);
  endtask

  task automatic do_reset();
    rst = 1; enable = 0;
    tick(0, 0);
    tick(0, 0);
    rst = 0;
    dcur = 0;
  endtask

  initial begin
    rst = 1; cdr_rst = 0; enable = 0; cdr_gain = 3'd0; cdr_fast_lock = 0;
    data_sample = 0; edge_sample = 0;
    tick(0, 0);
    tick(0, 0);
    chk_on = 1;
    chk("rst_vco", vco_control, 128);
    chk("rst_integ", $signed(integ_out), 0);
    chk("rst_state", cdr_state, 0);
    chk("rst_lock", cdr_lock, 0);
    chk("rst_pd", {pd_up, pd_dn}, 0);

    // Proportional + integral step with kp=2, ki=0
    do_reset();
    enable = 1; cdr_gain = 3'd2; cdr_fast_lock = 0;
    alt(1); alt(1);
    chk("t2_vco_first", vco_control, 132);
    chk("t2_integ_first", $signed(integ_out), 1);
    chk("t2_pd_up", pd_up, 1);
    for (int i = 0; i < 63; i++) alt(1);
    chk("t2_integ_64", $signed(integ_out), 64);
    alt(1);
    chk("t2_vco_133", vco_control, 133);

    // Fast-lock boost in ACQUIRE
    do_reset();
    enable = 1; cdr_gain = 3'd2; cdr_fast_lock = 1;
    alt(1); alt(1);
    chk("t3_vco_first", vco_control, 136);
    chk("t3_integ_first", $signed(integ_out), 4);
    alt(1);
    chk("t3_integ_second", $signed(integ_out), 8);

    // Balanced ups/dns: lock after the eighth good window
    do_reset();
    enable = 1; cdr_gain = 3'd2; cdr_fast_lock = 0;
    for (int i = 1; i <= 511; i++) alt(i % 2 == 1);
    chk("t4_state_511", cdr_state, 1);
    alt(0);
    chk("t4_state_512", cdr_state, 2);
    chk("t4_lock_512", cdr_lock, 1);
    cdr_fast_lock = 1;
    alt(1); alt(0);
    chk("t4_locked_vco", vco_control, 132);
    chk("t4_locked_integ", $signed(integ_out), 1);
    for (int i = 515; i <= 576; i++) alt(i % 2 == 1);
    chk("t4_still_locked", cdr_state, 2);

    // Transition-free input: HOLD, then back to ACQUIRE
    for (int i = 0; i < 64; i++) tick(dcur, dcur);
    chk("t5_hold_state", cdr_state, 3);
    chk("t5_hold_lock", cdr_lock, 1);
    chk("t5_hold_vco", vco_control, 128);
    for (int i = 0; i < 127; i++) tick(dcur, dcur);
    chk("t5_hold_late", cdr_state, 3);
    tick(dcur, dcur);
    chk("t5_acq_state", cdr_state, 1);
    chk("t5_acq_lock", cdr_lock, 0);
    chk("t5_integ_kept", $signed(integ_out), 0);

    // Soft reset and disable mid-operation
    cdr_rst = 1;
    tick(0, 0);
    cdr_rst = 0;
    chk("soft_rst_state", cdr_state, 0);
    chk("soft_rst_vco", vco_control, 128);
    dcur = 0;
    for (int i = 0; i < 5; i++) alt(1);
    enable = 0;
    tick(0, 0);
    chk("dis_integ", $signed(integ_out), 0);
    chk("dis_state", cdr_state, 0);

    // Integrator saturation and recovery
    do_reset();
    enable = 1; cdr_gain = 3'd2; cdr_fast_lock = 1;
    for (int i = 0; i < 5000; i++) alt(1);
    chk("t6_integ_sat", $signed(integ_out), 8191);
    chk("t6_vco_sat", vco_control, 255);
    for (int i = 0; i < 101; i++) alt(0);
    chk("t6_integ_down", $signed(integ_out), 7791);
    chk("t6_vco_down", vco_control, 241);
    chk("t6_pd_dn", pd_dn, 1);

    chk_on = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
